// File: rtl/mem_dump_uart_tx.sv
// ============================================================================
// mem_dump_uart_tx : streams a block of data memory out over an 8N1 UART line
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_dump_uart_tx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int ADDR_W       = 19,
    parameter int MEM_DEPTH    = 16911
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic [ADDR_W-1:0] extAddr,
    input  logic [7:0]        ext_d_out,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] bytes_sent
);

    localparam int          TW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]     TMAX     = TW'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] remain_q, remain_d;
    logic [ADDR_W-1:0] sent_q, sent_d;
    logic [ADDR_W-1:0] ext_addr_q, ext_addr_d;
    logic [7:0]        shift_q, shift_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              tx_q, busy_q, done_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        sent_d     = sent_q;
        ext_addr_d = ext_addr_q;
        shift_d    = shift_q;
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    remain_d = length;
                    sent_d   = '0;
                    state_d  = (length == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                ext_addr_d = addr_q;
                state_d    = S_LATCH;
            end
            S_LATCH: begin
                shift_d = ext_d_out;
                addr_d  = (addr_q == LAST_ADR) ? '0 : addr_q + ADDR_W'(1);
                timer_d = '0;
                state_d = S_START;
            end
            S_START: begin
                if (timer_q == TMAX) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DATA: begin
                if (timer_q == TMAX) begin
                    timer_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_STOP: begin
                if (timer_q == TMAX) begin
                    timer_d  = '0;
                    sent_d   = sent_q + ADDR_W'(1);
                    remain_d = remain_q - ADDR_W'(1);
                    state_d  = (remain_q == ADDR_W'(1)) ? S_DONE : S_FETCH;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            sent_q     <= '0;
            ext_addr_q <= '0;
            shift_q    <= '0;
            timer_q    <= '0;
            bit_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            sent_q     <= sent_d;
            ext_addr_q <= ext_addr_d;
            shift_q    <= shift_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
        end
    end

    // Line outputs are registered from the current state, so they trail it by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            tx_q   <= (state_q == S_START) ? 1'b0 :
                      (state_q == S_DATA)  ? shift_q[bit_idx_q] : 1'b1;
            busy_q <= (state_q == S_FETCH) || (state_q == S_LATCH) || (state_q == S_START) ||
                      (state_q == S_DATA)  || (state_q == S_STOP);
            done_q <= (state_q == S_DONE);
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign extAddr    = ext_addr_q;
    assign bytes_sent = sent_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_dump_uart_tx.sv
// ============================================================================
// tb_mem_dump_uart_tx : randomized self-checking bench with a UART line decoder
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mem_dump_uart_tx;

    localparam int CPB    = 4;
    localparam int ADDR_W = 19;
    localparam int DEPTH  = 16911;
    localparam int PER    = 10 * CPB + 2;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] length;
    logic [ADDR_W-1:0] extAddr;
    logic [7:0]        ext_d_out;
    logic              tx;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] bytes_sent;

    logic [7:0] mem [DEPTH];
    assign ext_d_out = mem[extAddr];

    mem_dump_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (ADDR_W),
        .MEM_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .extAddr   (extAddr),
        .ext_d_out (ext_d_out),
        .tx        (tx),
        .busy      (busy),
        .done      (done),
        .bytes_sent(bytes_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int busy_cycles = 0;
    int done_cnt    = 0;
    int done_cyc    = 0;
    int idle_viol   = 0;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (busy === 1'b1) busy_cycles <= busy_cycles + 1;
            if (done === 1'b1) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (busy !== 1'b1 && tx !== 1'b1) idle_viol <= idle_viol + 1;
        end
    end

    logic [7:0] got_byte [$];
    int         got_addr [$];
    int         got_cyc  [$];
    logic       got_stop [$];

    // Decodes frames from the line itself, sampling mid-bit; frames cut by reset are dropped.
    initial begin : uart_mon
        int         t0, a;
        logic [7:0] b;
        logic       ok, sb;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                t0 = cyc;
                a  = int'(extAddr);
                ok = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    repeat ((k == 0) ? (CPB + CPB / 2) : CPB) @(negedge clk);
                    b[k] = tx;
                    ok   = ok & (rst_n === 1'b1);
                end
                repeat (CPB) @(negedge clk);
                sb = tx;
                ok = ok & (rst_n === 1'b1);
                if (ok) begin
                    got_byte.push_back(b);
                    got_addr.push_back(a);
                    got_cyc.push_back(t0);
                    got_stop.push_back(sb);
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_dump(input int base, input int len, input bit poke, output int acc);
        int n0, b0, d0, lim;
        bit fin;
        n0 = got_byte.size();
        b0 = busy_cycles;
        d0 = done_cnt;
        base_addr = ADDR_W'(base);
        length    = ADDR_W'(len);
        start     = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        @(negedge clk); #1;
        start     = 1'b0;
        base_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
        length    = ADDR_W'($urandom_range(1, 5));
        lim = len * PER + 20;
        fin = 1'b0;
        for (int c = 0; c < lim && !fin; c++) begin
            @(negedge clk); #1;
            if (poke && c == 60) start = 1'b1;
            if (poke && c == 62) start = 1'b0;
            if (done_cnt != d0) fin = 1'b1;
        end
        chk("done_timeout", 32'(fin), 32'd1);
        repeat (4) @(negedge clk);
        #1;
        chk("frame_count", 32'(got_byte.size() - n0), 32'(len));
        for (int i = 0; i < len && n0 + i < got_byte.size(); i++) begin
            chk("byte", 32'(got_byte[n0 + i]), 32'(mem[(base + i) % DEPTH]));
            chk("ext_addr", 32'(got_addr[n0 + i]), 32'((base + i) % DEPTH));
            chk("stop_bit", 32'(got_stop[n0 + i]), 32'd1);
            if (i > 0) chk("frame_spacing", 32'(got_cyc[n0 + i] - got_cyc[n0 + i - 1]), 32'(PER));
        end
        if (len > 0 && got_byte.size() > n0)
            chk("first_edge_lat", 32'(got_cyc[n0] - acc), 32'd3);
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("bytes_sent", 32'(bytes_sent), 32'(len));
        chk("busy_cycles", 32'(busy_cycles - b0), 32'(len * PER));
    endtask

    initial begin : main
        int acc, ea, r, n0, d0, lim;
        int dcyc [3];
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
        mem[100] = 8'hA5; mem[101] = 8'h3C; mem[102] = 8'hFF;
        mem[16910] = 8'h01; mem[0] = 8'h02; mem[1] = 8'h03;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_extaddr", 32'(extAddr), 32'd0);
        chk("rst_bytes_sent", 32'(bytes_sent), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;

        run_dump(100, 3, 1'b0, acc);
        run_dump(16910, 3, 1'b0, acc);

        // Zero length: no frame, no busy, address port untouched.
        ea = int'(extAddr);
        run_dump($urandom_range(0, DEPTH - 1), 0, 1'b0, acc);
        chk("zero_extaddr", 32'(extAddr), 32'(ea));
        chk("zero_done_window", 32'((done_cyc - acc) >= 1 && (done_cyc - acc) <= 2), 32'd1);

        for (int k = 0; k < 3; k++)
            run_dump($urandom_range(0, DEPTH - 1), $urandom_range(1, 4), 1'b0, acc);

        run_dump($urandom_range(0, DEPTH - 1), 3, 1'b1, acc);

        // Reset in the middle of data bit 3 of the first frame.
        base_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
        length    = ADDR_W'(3);
        start     = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_bytes_sent", 32'(bytes_sent), 32'd0);
        repeat (6) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        run_dump($urandom_range(0, DEPTH - 1), 1, 1'b0, acc);

        // Start held high: dumps repeat back to back.
        r  = $urandom_range(0, DEPTH - 1);
        n0 = got_byte.size();
        d0 = done_cnt;
        base_addr = ADDR_W'(r);
        length    = ADDR_W'(2);
        start     = 1'b1;
        lim = 3 * (2 * PER + 2) + 30;
        for (int c = 0; c < lim && (done_cnt - d0) < 3; c++) begin
            @(negedge clk); #1;
            if (done_cnt - d0 >= 1 && done_cnt - d0 <= 3) dcyc[done_cnt - d0 - 1] = done_cyc;
        end
        start = 1'b0;
        chk("b2b_timeout", 32'(done_cnt - d0), 32'd3);
        repeat (10) @(negedge clk);
        #1;
        chk("b2b_done_total", 32'(done_cnt - d0), 32'd3);
        chk("b2b_period_1", 32'(dcyc[1] - dcyc[0]), 32'(2 * PER + 2));
        chk("b2b_period_2", 32'(dcyc[2] - dcyc[1]), 32'(2 * PER + 2));
        chk("b2b_frames", 32'(got_byte.size() - n0), 32'd6);
        for (int i = 0; i < 6 && n0 + i < got_byte.size(); i++)
            chk("b2b_byte", 32'(got_byte[n0 + i]), 32'(mem[(r + (i % 2)) % DEPTH]));
        chk("tx_high_when_idle", 32'(idle_viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
